// File: rtl/bfm_apb_bridge_mux_if.sv
// Bus bundle for bfm_apb_bridge_mux: one upstream APB3 port and NSLAVES downstream APB ports.
// The bridge takes the slave modport; the master model and slave models take the master modport.
interface bfm_apb_bridge_mux_if #(
  parameter int unsigned NSLAVES = 16,
  parameter int unsigned AWIDTH  = 32,
  parameter int unsigned DWIDTH  = 32
);
  // Upstream (from the APB master model)
  logic                      PSEL_PM;
  logic [AWIDTH-1:0]         PADDR_PM;
  logic                      PWRITE_PM;
  logic                      PENABLE_PM;
  logic [DWIDTH-1:0]         PWDATA_PM;
  logic [DWIDTH-1:0]         PRDATA_PM;
  logic                      PREADY_PM;
  logic                      PSLVERR_PM;

  // Downstream (towards the slave models); address/data/control are shared by all slots
  logic [NSLAVES-1:0]        PSEL_SC;
  logic [AWIDTH-1:0]         PADDR_SC;
  logic                      PWRITE_SC;
  logic                      PENABLE_SC;
  logic [DWIDTH-1:0]         PWDATA_SC;
  logic [NSLAVES*DWIDTH-1:0] PRDATA_SC;
  logic [NSLAVES-1:0]        PREADY_SC;
  logic [NSLAVES-1:0]        PSLVERR_SC;

  modport master (
    output PSEL_PM, PADDR_PM, PWRITE_PM, PENABLE_PM, PWDATA_PM,
    input  PRDATA_PM, PREADY_PM, PSLVERR_PM,
    input  PSEL_SC, PADDR_SC, PWRITE_SC, PENABLE_SC, PWDATA_SC,
    output PRDATA_SC, PREADY_SC, PSLVERR_SC
  );

  modport slave (
    input  PSEL_PM, PADDR_PM, PWRITE_PM, PENABLE_PM, PWDATA_PM,
    output PRDATA_PM, PREADY_PM, PSLVERR_PM,
    output PSEL_SC, PADDR_SC, PWRITE_SC, PENABLE_SC, PWDATA_SC,
    input  PRDATA_SC, PREADY_SC, PSLVERR_SC
  );
endinterface

// File: rtl/bfm_apb_bridge_mux.sv
// APB3 upstream port bridged to NSLAVES downstream APB ports, slot decoded from address bits.
// Optional ACCESS-phase watchdog is built in when BFM_APB_TIMEOUT_EN is defined.
module bfm_apb_bridge_mux #(
  parameter int unsigned NSLAVES    = 16,
  parameter int unsigned DEC_LSB    = 24,
  parameter int unsigned AWIDTH     = 32,
  parameter int unsigned DWIDTH     = 32,
  parameter logic [15:0] SLAVE_MASK = 16'hFFFF,
  parameter int unsigned TIMEOUT    = 255
) (
  input logic                 PCLK,
  input logic                 PRESETN,
  bfm_apb_bridge_mux_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e              r_state, w_state_d;
  logic                r_penable_prev;
  logic [3:0]          r_slot, w_slot_d;

  logic [NSLAVES-1:0]  r_psel_sc, w_psel_sc_d;
  logic                r_penable_sc, w_penable_sc_d;
  logic                r_pwrite_sc, w_pwrite_sc_d;
  logic [AWIDTH-1:0]   r_paddr_sc, w_paddr_sc_d;
  logic [DWIDTH-1:0]   r_pwdata_sc, w_pwdata_sc_d;

  logic                r_pready_pm, w_pready_pm_d;
  logic                r_pslverr_pm, w_pslverr_pm_d;
  logic [DWIDTH-1:0]   r_prdata_pm, w_prdata_pm_d;

  logic [3:0]          w_dec_slot;
  logic                w_start;
  logic                w_mapped;
  logic [NSLAVES-1:0]  w_dec_onehot;
  logic                w_sel_ready;
  logic                w_sel_err;
  logic [DWIDTH-1:0]   w_sel_rdata;
  logic                w_timeout;
  logic                w_release;

  assign w_dec_slot = bus.PADDR_PM[DEC_LSB +: 4];
  assign w_start    = bus.PSEL_PM & bus.PENABLE_PM & ~r_penable_prev;
  assign w_mapped   = (32'(w_dec_slot) < NSLAVES) && SLAVE_MASK[w_dec_slot];

  // Decode of the incoming slot and mux of the captured slot's response
  always_comb begin
    w_dec_onehot = '0;
    w_sel_ready  = 1'b0;
    w_sel_err    = 1'b0;
    w_sel_rdata  = '0;
    for (int n = 0; n < NSLAVES; n++) begin
      if (w_dec_slot == 4'(n)) begin
        w_dec_onehot[n] = 1'b1;
      end
      if (r_slot == 4'(n)) begin
        w_sel_ready = bus.PREADY_SC[n];
        w_sel_err   = bus.PSLVERR_SC[n];
        w_sel_rdata = bus.PRDATA_SC[n*DWIDTH +: DWIDTH];
      end
    end
  end

`ifdef BFM_APB_TIMEOUT_EN
  logic [15:0] r_tcnt, w_tcnt_d;

  // Firing on the count that would reach TIMEOUT gives exactly TIMEOUT unready ACCESS cycles
  assign w_timeout = (r_tcnt == 16'(TIMEOUT - 1));

  always_comb begin
    w_tcnt_d = r_tcnt;
    if (r_state == StSetup) begin
      w_tcnt_d = '0;
    end else if ((r_state == StAccess) && !w_sel_ready) begin
      w_tcnt_d = r_tcnt + 16'd1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= w_tcnt_d;
    end
  end
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    w_state_d      = r_state;
    w_slot_d       = r_slot;
    w_psel_sc_d    = r_psel_sc;
    w_penable_sc_d = r_penable_sc;
    w_pwrite_sc_d  = r_pwrite_sc;
    w_paddr_sc_d   = r_paddr_sc;
    w_pwdata_sc_d  = r_pwdata_sc;
    w_pready_pm_d  = 1'b0;
    w_pslverr_pm_d = 1'b0;
    w_prdata_pm_d  = '0;
    w_release      = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_slot_d = w_dec_slot;
          if (w_mapped) begin
            w_state_d     = StSetup;
            w_psel_sc_d   = w_dec_onehot;
            w_paddr_sc_d  = bus.PADDR_PM;
            w_pwdata_sc_d = bus.PWDATA_PM;
            w_pwrite_sc_d = bus.PWRITE_PM;
          end else begin
            w_state_d      = StResp;
            w_pready_pm_d  = 1'b1;
            w_pslverr_pm_d = 1'b1;
          end
        end
      end
      StSetup: begin
        w_state_d      = StAccess;
        w_penable_sc_d = 1'b1;
      end
      StAccess: begin
        if (w_sel_ready) begin
          w_state_d      = StResp;
          w_release      = 1'b1;
          w_pready_pm_d  = 1'b1;
          w_pslverr_pm_d = w_sel_err;
          w_prdata_pm_d  = r_pwrite_sc ? '0 : w_sel_rdata;
        end else if (w_timeout) begin
          w_state_d      = StResp;
          w_release      = 1'b1;
          w_pready_pm_d  = 1'b1;
          w_pslverr_pm_d = 1'b1;
        end
      end
      StResp: begin
        w_state_d = StIdle;
      end
    endcase

    if (w_release) begin
      w_psel_sc_d    = '0;
      w_penable_sc_d = 1'b0;
      w_pwrite_sc_d  = 1'b0;
      w_paddr_sc_d   = '0;
      w_pwdata_sc_d  = '0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state        <= StIdle;
      r_penable_prev <= 1'b0;
      r_slot         <= '0;
      r_psel_sc      <= '0;
      r_penable_sc   <= 1'b0;
      r_pwrite_sc    <= 1'b0;
      r_paddr_sc     <= '0;
      r_pwdata_sc    <= '0;
      r_pready_pm    <= 1'b0;
      r_pslverr_pm   <= 1'b0;
      r_prdata_pm    <= '0;
    end else begin
      r_state        <= w_state_d;
      r_penable_prev <= bus.PENABLE_PM;
      r_slot         <= w_slot_d;
      r_psel_sc      <= w_psel_sc_d;
      r_penable_sc   <= w_penable_sc_d;
      r_pwrite_sc    <= w_pwrite_sc_d;
      r_paddr_sc     <= w_paddr_sc_d;
      r_pwdata_sc    <= w_pwdata_sc_d;
      r_pready_pm    <= w_pready_pm_d;
      r_pslverr_pm   <= w_pslverr_pm_d;
      r_prdata_pm    <= w_prdata_pm_d;
    end
  end

  assign bus.PSEL_SC    = r_psel_sc;
  assign bus.PENABLE_SC = r_penable_sc;
  assign bus.PWRITE_SC  = r_pwrite_sc;
  assign bus.PADDR_SC   = r_paddr_sc;
  assign bus.PWDATA_SC  = r_pwdata_sc;
  assign bus.PREADY_PM  = r_pready_pm;
  assign bus.PSLVERR_PM = r_pslverr_pm;
  assign bus.PRDATA_PM  = r_prdata_pm;

endmodule

// File: tb/tb_bfm_apb_bridge_mux.sv
// Scoreboard bench for bfm_apb_bridge_mux: a 16-slot instance and a 4-slot instance with
// slot 2 masked off, driven by one APB master model and simple wait-state slave models.
module tb_bfm_apb_bridge_mux;

  logic clk = 1'b0;
  logic PRESETN = 1'b0;
  always #5 clk = ~clk;

`ifdef BFM_APB_TIMEOUT_EN
  localparam int HangCycles = 5;
`else
  localparam int HangCycles = 1005;
`endif

  bfm_apb_bridge_mux_if #(.NSLAVES(16), .AWIDTH(32), .DWIDTH(32)) a ();
  bfm_apb_bridge_mux_if #(.NSLAVES(4),  .AWIDTH(32), .DWIDTH(32)) b ();

  bfm_apb_bridge_mux #(
    .NSLAVES(16), .DEC_LSB(24), .AWIDTH(32), .DWIDTH(32), .SLAVE_MASK(16'hFFFF), .TIMEOUT(8)
  ) u_dut_a (
    .PCLK(clk), .PRESETN(PRESETN), .bus(a)
  );

  bfm_apb_bridge_mux #(
    .NSLAVES(4), .DEC_LSB(24), .AWIDTH(32), .DWIDTH(32), .SLAVE_MASK(16'h000B), .TIMEOUT(8)
  ) u_dut_b (
    .PCLK(clk), .PRESETN(PRESETN), .bus(b)
  );

  typedef struct packed {
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;
    logic [15:0] psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
  } obs_t;

  typedef struct {
    int          d;
    logic        err;
    logic [31:0] rd;
    int          cyc;
  } up_t;

  typedef struct {
    int          d;
    logic [15:0] psel;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        wr;
    int          cyc;
  } dn_t;

  up_t         q_up[$];
  dn_t         q_dn[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          s_wait = 0;
  logic [15:0] s_err = '0;
  int          wcnt_a = 0;
  int          wcnt_b = 0;
  int          pready_cnt0 = 0;
  logic [1:0]  prev_pready = '0;
  logic [1:0]  prev_en = '0;
  logic [1:0]  prev_setup = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] rd_a(input int n);
    return (n == 5) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(n) * 32'h0101;
  endfunction

  function automatic obs_t obs(input int d);
    if (d == 0) begin
      return {a.PREADY_PM, a.PSLVERR_PM, a.PRDATA_PM, a.PSEL_SC, a.PENABLE_SC, a.PWRITE_SC,
              a.PADDR_SC, a.PWDATA_SC};
    end
    return {b.PREADY_PM, b.PSLVERR_PM, b.PRDATA_PM, 12'h000, b.PSEL_SC, b.PENABLE_SC,
            b.PWRITE_SC, b.PADDR_SC, b.PWDATA_SC};
  endfunction

  // Slave models: selected slot becomes ready after s_wait ACCESS cycles; the other slots
  // always claim ready so a wrong mux select finishes early
  assign a.PSLVERR_SC = s_err;
  assign b.PSLVERR_SC = s_err[3:0];

  always @(negedge clk) begin
    if (a.PENABLE_SC) begin
      a.PREADY_SC = (wcnt_a >= s_wait) ? a.PSEL_SC : ~a.PSEL_SC;
      wcnt_a++;
    end else begin
      a.PREADY_SC = ~a.PSEL_SC;
      wcnt_a = 0;
    end
    if (b.PENABLE_SC) begin
      b.PREADY_SC = (wcnt_b >= s_wait) ? b.PSEL_SC : ~b.PSEL_SC;
      wcnt_b++;
    end else begin
      b.PREADY_SC = ~b.PSEL_SC;
      wcnt_b = 0;
    end
  end

  // Scoreboard: upstream responses and downstream SETUP phases against queued expectations
  always @(negedge clk) begin
    obs_t o;
    up_t  e;
    dn_t  f;
    for (int d = 0; d < 2; d++) begin
      o = obs(d);
      chk_eq($sformatf("d%0d_psel_onehot", d), 128'($onehot0(o.psel)), 128'd1);
      if (o.pready) begin
        if (d == 0) pready_cnt0++;
        if (q_up.size() != 0 && q_up[0].d == d) begin
          e = q_up.pop_front();
          chk_eq($sformatf("d%0d_pslverr", d), 128'(o.pslverr), 128'(e.err));
          chk_eq($sformatf("d%0d_prdata", d), 128'(o.prdata), 128'(e.rd));
          chk_eq($sformatf("d%0d_pready_cycle", d), 128'(cyc), 128'(e.cyc));
        end else begin
          chk_eq($sformatf("d%0d_pready_unexpected", d), 128'(o.pready), '0);
        end
      end else if (prev_pready[d]) begin
        chk_eq($sformatf("d%0d_resp_clear", d), 128'({o.pslverr, o.prdata}), '0);
      end
      if (o.psel != 0 && !o.penable) begin
        if (q_dn.size() != 0 && q_dn[0].d == d) begin
          f = q_dn.pop_front();
          chk_eq($sformatf("d%0d_setup_bus", d), 128'({o.psel, o.paddr, o.pwdata, o.pwrite}),
                 128'({f.psel, f.addr, f.wd, f.wr}));
          chk_eq($sformatf("d%0d_setup_cycle", d), 128'(cyc), 128'(f.cyc));
        end else begin
          chk_eq($sformatf("d%0d_psel_unexpected", d), 128'(o.psel), '0);
        end
      end
      if (o.penable && !prev_en[d]) begin
        chk_eq($sformatf("d%0d_penable_after_setup", d), 128'(prev_setup[d]), 128'd1);
      end
      prev_pready[d] = o.pready;
      prev_en[d]     = o.penable;
      prev_setup[d]  = (o.psel != 0) && !o.penable;
    end
  end

  task automatic drive(input int d, input logic sel, input logic en, input logic [31:0] addr,
                       input logic wr, input logic [31:0] wd);
    if (d == 0) begin
      a.PSEL_PM = sel; a.PENABLE_PM = en; a.PADDR_PM = addr; a.PWRITE_PM = wr; a.PWDATA_PM = wd;
    end else begin
      b.PSEL_PM = sel; b.PENABLE_PM = en; b.PADDR_PM = addr; b.PWRITE_PM = wr; b.PWDATA_PM = wd;
    end
  endtask

  // One upstream transfer; lat is PREADY_PM delay from the start edge, 0 meaning unmapped slot
  task automatic xfer(input int d, input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input logic err, input logic [31:0] rd, input int lat);
    up_t e;
    dn_t f;
    int  c0;
    @(posedge clk); #1 drive(d, 1'b1, 1'b0, addr, wr, wd);
    @(posedge clk); #1 drive(d, 1'b1, 1'b1, addr, wr, wd);
    c0 = cyc + 1;
    if (lat != 0) begin
      f.d = d; f.psel = 16'h0001 << addr[27:24]; f.addr = addr; f.wd = wd; f.wr = wr; f.cyc = c0;
      q_dn.push_back(f);
    end
    e.d = d; e.err = err; e.rd = rd; e.cyc = c0 + lat;
    q_up.push_back(e);
    for (int i = 0; i < lat + 20 && q_up.size() != 0; i++) @(negedge clk);
    if (q_up.size() != 0) begin
      chk_eq("xfer_no_response", 128'(q_up.size()), '0);
      q_up.delete();
      q_dn.delete();
    end
    @(posedge clk); #1 drive(d, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1ms, required to finish");
    $fatal(1);
  end

  initial begin
    dn_t f;
    int  hang_base;
    for (int n = 0; n < 16; n++) a.PRDATA_SC[n*32 +: 32] = rd_a(n);
    for (int n = 0; n < 4; n++) b.PRDATA_SC[n*32 +: 32] = 32'h2000_0000 + 32'(n);
    drive(0, 1'b0, 1'b0, '0, 1'b0, '0);
    drive(1, 1'b0, 1'b0, '0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1 chk_eq("reset_state_a", 128'(obs(0)), '0);
    chk_eq("reset_state_b", 128'(obs(1)), '0);
    PRESETN = 1'b1;

    xfer(0, 32'h0300_0010, 1'b1, 32'hA5A5_0001, 1'b0, 32'h0, 2);
    s_wait = 2;
    xfer(0, 32'h0500_0000, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 4);
    s_wait = 0;
    xfer(0, 32'hF500_0004, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 2);
    s_err = 16'h0003;
    xfer(0, 32'h0100_0000, 1'b0, 32'h0, 1'b1, rd_a(1), 2);
    s_err = 16'h0001;
    xfer(0, 32'h0100_0000, 1'b0, 32'h0, 1'b0, rd_a(1), 2);
    s_err = 16'h0000;
    xfer(0, 32'h0700_0000, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 2);
    s_wait = 1;
    xfer(0, 32'h0F00_0000, 1'b0, 32'h0, 1'b0, rd_a(15), 3);
    s_wait = 0;

    xfer(1, 32'h0700_0000, 1'b0, 32'h0, 1'b1, 32'h0, 0);
    xfer(1, 32'h0200_0000, 1'b0, 32'h0, 1'b1, 32'h0, 0);
    xfer(1, 32'h0300_0000, 1'b0, 32'h0, 1'b0, 32'h2000_0003, 2);
    xfer(1, 32'h0100_0004, 1'b1, 32'hCAFE_0001, 1'b0, 32'h0, 2);

    s_wait = 1_000_000;
`ifdef BFM_APB_TIMEOUT_EN
    xfer(0, 32'h0200_0000, 1'b0, 32'h0, 1'b1, 32'h0, 9);
`endif

    // Slave never answers: no upstream response, then reset drops the transfer mid-ACCESS
    @(posedge clk); #1 drive(0, 1'b1, 1'b0, 32'h0600_0000, 1'b0, '0);
    @(posedge clk); #1 drive(0, 1'b1, 1'b1, 32'h0600_0000, 1'b0, '0);
    f.d = 0; f.psel = 16'h0040; f.addr = 32'h0600_0000; f.wd = '0; f.wr = 1'b0; f.cyc = cyc + 1;
    q_dn.push_back(f);
    hang_base = pready_cnt0;
    repeat (HangCycles) @(negedge clk);
    chk_eq("hang_no_pready", 128'(pready_cnt0 - hang_base), '0);
    chk_eq("hang_in_access", 128'(a.PENABLE_SC), 128'd1);
    @(posedge clk); #3 PRESETN = 1'b0;
    #1 chk_eq("reset_mid_access", 128'(obs(0)), '0);
    drive(0, 1'b0, 1'b0, '0, 1'b0, '0);
    s_wait = 0;
    repeat (2) @(posedge clk);
    #1 PRESETN = 1'b1;
    xfer(0, 32'h0000_0040, 1'b0, 32'h0, 1'b0, rd_a(0), 2);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
